// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if: upstream capture and downstream result/flags handshake of the ALU result stage
interface alu_result_stage_if #(
    parameter int N  = 8,
    parameter int CW = 8
);
    logic [N-1:0]  in_result;
    logic [1:0]    in_op;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  out_result;
    logic [1:0]    out_op;
    logic          out_zero;
    logic          out_negative;
    logic          out_parity;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_count;

    modport master (
        output in_result, in_op, in_valid, out_ready,
        input  in_ready, out_result, out_op, out_zero, out_negative, out_parity, out_valid, out_count
    );

    modport slave (
        input  in_result, in_op, in_valid, out_ready,
        output in_ready, out_result, out_op, out_zero, out_negative, out_parity, out_valid, out_count
    );
endinterface

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered ALU result stage with status flags and a 2-entry skid buffer
module alu_result_stage #(
    parameter int N  = 8,
    parameter int CW = 8
) (
    input  logic clk,
    input  logic rst_n,
    alu_result_stage_if.slave bus
);
    // bit 0 = main entry valid (out_valid), bit 1 = skid entry valid (~in_ready)
    typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b11} occ_t;
    typedef struct packed {
        logic [N-1:0] result;
        logic [1:0]   op;
        logic         zero;
        logic         negative;
        logic         parity;
    } entry_t;

    occ_t          state, state_d;
    entry_t        main_q, skid_q, incoming;
    logic [CW-1:0] count_q;
    logic          acc, dlv, load_main, load_skid;

    always_comb begin
        incoming = '{result: bus.in_result, op: bus.in_op, zero: ~|bus.in_result,
                     negative: bus.in_result[N-1], parity: ^bus.in_result};
        acc = bus.in_valid & ~state[1];
        dlv = state[0] & bus.out_ready;
        load_main = (state == FULL) ? dlv : acc & (dlv | ~state[0]);
        load_skid = (state == ONE) & acc & ~dlv;
        state_d = (state == EMPTY) ? (acc ? ONE : EMPTY)
                : (state == ONE)   ? (load_skid ? FULL : (dlv & ~acc) ? EMPTY : ONE)
                :                    (dlv ? ONE : FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            count_q <= '0;
        end else begin
            state <= state_d;
            if (load_main) main_q <= (state == FULL) ? skid_q : incoming;
            if (load_skid) skid_q <= incoming;
            if (dlv) count_q <= count_q + CW'(1);
        end
    end

    assign bus.in_ready     = ~state[1];
    assign bus.out_valid    = state[0];
    assign bus.out_result   = main_q.result;
    assign bus.out_op       = main_q.op;
    assign bus.out_zero     = main_q.zero;
    assign bus.out_negative = main_q.negative;
    assign bus.out_parity   = main_q.parity;
    assign bus.out_count    = count_q;
endmodule
